dcache_direct_wb: RTL and testbench
===================================

Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MIPS core's data-memory port and a slow block-wide memory.
- Serves core word reads and writes in zero wait cycles on a hit.
- On a miss, raises proc_stall while it writes back any dirty victim and refills the block, then completes the access.
- The core freezes its PC and holds the request stable while proc_stall is high.

Parameters:
- ADDR_W, 30, core word-address width; byte address = {proc_addr, 2'b00}.
- NUM_BLOCKS, 8, number of cache lines; power of two, at least 2.
- Line size is fixed at 4 words (128 bits). IDX_W = log2(NUM_BLOCKS). TAG_W = ADDR_W - 2 - IDX_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- proc_read  in  1  core load request.
- proc_write  in  1  core store request.
- proc_addr  in  ADDR_W  word address; [1:0] selects the word, [IDX_W+1:2] the index, the rest the tag.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  core must hold its request and PC while high.
- mem_read  out  1  block refill request.
- mem_write  out  1  block write-back request.
- mem_addr  out  ADDR_W-2  memory block address.
- mem_wdata  out  128  victim block; word 0 in [31:0].
- mem_rdata  in  128  refill block; word 0 in [31:0].
- mem_ready  in  1  one-cycle pulse; the memory has accepted the write or returned mem_rdata.

Behaviour:
- Storage: per line, valid, dirty, tag and 4x32 data; all registers, no SRAM macro.
- Reset (async, rst=1): all valid and dirty bits clear; state IDLE; mem_read=mem_write=0; mem_addr=0; mem_wdata=0; proc_stall=0; proc_rdata=0. Data and tag contents are don't-care.
- Request: req = proc_read | proc_write. If both are high, the access is treated as a write; proc_rdata is don't-care.
- hit = valid[idx] & (tag[idx] == addr_tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no req: proc_stall=0; memory outputs idle.
- IDLE, req and hit:
  - proc_stall=0.
  - Read: proc_rdata = selected word, combinational in the same cycle.
  - Write: at the clock edge, the selected word is replaced by proc_wdata and dirty[idx] is set.
- IDLE, req and miss: proc_stall=1 combinationally in that cycle.
  - If valid[idx] & dirty[idx]: next state WRITEBACK.
  - Otherwise: next state ALLOCATE.
- WRITEBACK:
  - mem_write=1, mem_addr={tag[idx], idx}, mem_wdata=line[idx]; all held constant.
  - proc_stall=1.
  - On mem_ready: next state ALLOCATE.
- ALLOCATE:
  - mem_read=1, mem_addr=proc_addr[ADDR_W-1:2]; proc_stall=1.
  - On mem_ready, at that edge: line[idx]=mem_rdata, tag written, valid=1, dirty=0; next state IDLE.
  - The following IDLE cycle hits and completes normally.
- Miss latency: clean miss = ALLOCATE cycles + 1; dirty miss = WRITEBACK cycles + ALLOCATE cycles + 1.
- Memory outputs are registered, driven from the state and line registers only; no combinational path from proc_* to mem_*.
- mem_read and mem_write are never high together.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Request dropped while stalled (the core must not do this): the FSM still completes the current fill and returns to IDLE; no corruption.
- Reset mid-miss: returns to IDLE at once and drops the memory request; the whole cache is invalid afterwards.
- Index wrap: addresses that differ only in tag map to the same line and evict each other; this is the expected conflict behaviour.

Decomposition:
- Shared package dcache_pkg holds:
  - state encoding: IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2;
  - LINE_WORDS=4 and LINE_W=128;
  - an address-split helper giving tag, index and word offset.
- One natural sub-module, dcache_line_array: valid/dirty/tag/data registers with async clear of valid/dirty, a word-write port, a line-fill port, and combinational read of one line.
- The FSM and hit logic stay in dcache_direct_wb.

Test Plan:
- Reset, then read proc_addr=0x10; memory returns 0x44444444_33333333_22222222_11111111 after a 3-cycle delay -> mem_read high for 3 cycles with mem_addr=0x4, stall for 4 cycles, proc_rdata=0x11111111, mem_write never asserted.
- Immediately read 0x11, 0x12, 0x13 -> each has stall=0 in the same cycle; data 0x22222222, 0x33333333, 0x44444444.
- Write 0xDEADBEEF to 0x12, then read 0x12 -> no stall on either access; the read returns 0xDEADBEEF; no memory traffic.
- With NUM_BLOCKS=8, read 0x30 (same index, new tag) -> WRITEBACK with mem_addr=0x4 and mem_wdata word2=0xDEADBEEF, then ALLOCATE with mem_addr=0xC, then the read completes.
- Assert rst during ALLOCATE -> mem_read drops asynchronously; a later read of 0x30 misses again.
- proc_read and proc_write both high with a hit on a cached address -> treated as a write: dirty set, word updated.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, line geometry and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  // Helpers operate on a zero-extended address of this width.
  localparam int unsigned SPLIT_W    = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  // Word offset within a line.
  function automatic logic [1:0] addr_off(input logic [SPLIT_W-1:0] addr);
    return addr[1:0];
  endfunction

  // Line index; caller casts to its index width.
  function automatic logic [SPLIT_W-1:0] addr_idx(input logic [SPLIT_W-1:0] addr,
                                                  input int unsigned idx_w);
    return (addr >> 2) & ((SPLIT_W'(1) << idx_w) - SPLIT_W'(1));
  endfunction

  // Tag bits above the index; caller casts to its tag width.
  function automatic logic [SPLIT_W-1:0] addr_tag(input logic [SPLIT_W-1:0] addr,
                                                  input int unsigned idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Register-based line storage: valid/dirty/tag/data per line, word write, line fill, one read port.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned TAG_W      = 25,
  localparam int unsigned IDX_W     = $clog2(NUM_BLOCKS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // word write from a store hit; marks the line dirty
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [1:0]        wr_off_i,
  input  logic [31:0]       wr_data_i,
  // whole-line fill from memory; line becomes valid and clean
  input  logic              fill_en_i,
  input  logic [IDX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  // combinational read of one line
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  // Status bits: cleared on reset, set by fill/write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
      dirty_q[fill_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload; contents after reset are don't-care.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][{wr_off_i, 5'b0} +: WORD_W] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back write-allocate data cache: zero-wait hits, stall on miss for write-back and refill.
module dcache_direct_wb
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              proc_read_i,
  input  logic              proc_write_i,
  input  logic [ADDR_W-1:0] proc_addr_i,
  input  logic [31:0]       proc_wdata_i,
  output logic [31:0]       proc_rdata_o,
  output logic              proc_stall_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  state_e            state_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_off;
  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic              req;
  logic              hit;
  logic              in_idle;
  logic              wr_en;
  logic              fill_en;
  logic [31:0]       sel_word;

  assign req_off = addr_off(SPLIT_W'(proc_addr_i));
  assign req_idx = IDX_W'(addr_idx(SPLIT_W'(proc_addr_i), IDX_W));
  assign req_tag = TAG_W'(addr_tag(SPLIT_W'(proc_addr_i), IDX_W));

  dcache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en_i     (wr_en),
    .wr_idx_i    (req_idx),
    .wr_off_i    (req_off),
    .wr_data_i   (proc_wdata_i),
    .fill_en_i   (fill_en),
    .fill_idx_i  (mem_addr_q[IDX_W-1:0]),
    .fill_tag_i  (mem_addr_q[ADDR_W-3:IDX_W]),
    .fill_data_i (mem_rdata_i),
    .rd_idx_i    (req_idx),
    .rd_valid_o  (line_valid),
    .rd_dirty_o  (line_dirty),
    .rd_tag_o    (line_tag),
    .rd_line_o   (line_data)
  );

  // Hit detection and core-side handshake; stall rises in the same cycle a miss is seen.
  always_comb begin
    req      = proc_read_i | proc_write_i;
    hit      = line_valid & (line_tag == req_tag);
    in_idle  = (state_q == IDLE);
    sel_word = line_data[{req_off, 5'b0} +: WORD_W];
    wr_en    = in_idle & proc_write_i & hit;
    // Fill goes to the block latched in mem_addr, so a dropped request cannot misdirect it.
    fill_en  = (state_q == ALLOCATE) & mem_ready_i;
    proc_stall_o = ~in_idle | (req & ~hit);
    proc_rdata_o = (in_idle & proc_read_i & ~proc_write_i & hit) ? sel_word : 32'd0;
  end

  // Miss FSM; memory-side outputs are registered alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, req_idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= proc_addr_i[ADDR_W-1:2];
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready_i) begin
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= proc_addr_i[ADDR_W-1:2];
          end
        end
        ALLOCATE: begin
          if (mem_ready_i) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed self-checking bench for dcache_direct_wb with a fixed-latency block memory model.
module tb_dcache_direct_wb;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned MEM_LAT = 3;

  logic              clk;
  logic              rst;
  logic              proc_read;
  logic              proc_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_wdata;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  int n_cmp;
  int n_bad;

  // results of the last run_access
  int           r_stall;
  int           r_mr;
  int           r_mw;
  logic [27:0]  r_mr_addr;
  logic [27:0]  r_mw_addr;
  logic [127:0] r_mw_data;
  logic [31:0]  r_rdata;
  logic         r_timeout;
  logic         r_both;

  dcache_direct_wb #(.ADDR_W(ADDR_W), .NUM_BLOCKS(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .proc_read_i  (proc_read),
    .proc_write_i (proc_write),
    .proc_addr_i  (proc_addr),
    .proc_wdata_i (proc_wdata),
    .proc_rdata_o (proc_rdata),
    .proc_stall_o (proc_stall),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ready_i  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access from posedge+1 until the cache stops stalling, acting as a
  // MEM_LAT-cycle memory; records traffic for the calling test to check.
  task automatic run_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [127:0] fill);
    int req_cyc;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    r_stall = 0; r_mr = 0; r_mw = 0;
    r_mr_addr = '0; r_mw_addr = '0; r_mw_data = '0; r_rdata = '0;
    r_timeout = 1'b1; r_both = 1'b0;
    req_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (mem_read && mem_write) r_both = 1'b1;
      if (mem_read)  begin r_mr++; r_mr_addr = mem_addr; end
      if (mem_write) begin r_mw++; r_mw_addr = mem_addr; r_mw_data = mem_wdata; end
      if (!proc_stall) begin
        r_rdata   = proc_rdata;
        r_timeout = 1'b0;
        break;
      end
      r_stall++;
      if (mem_read || mem_write) begin
        req_cyc++;
        if (req_cyc == MEM_LAT) begin
          mem_ready = 1'b1;
          mem_rdata = fill;
          req_cyc   = 0;
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    @(posedge clk); #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    if (r_timeout) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout addr=%h: cache still stalling after 40 cycles", addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
    proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", proc_stall); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_memreq got=%b exp=00", {mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (mem_wdata !== 128'h0) begin n_bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    n_cmp++; if (proc_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", proc_rdata); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss;
    run_access(1'b1, 1'b0, 30'h10, 32'h0, 128'h44444444_33333333_22222222_11111111);
    n_cmp++; if (r_stall !== 4) begin n_bad++; $display("FAIL clean_miss_stall got=%0d exp=4", r_stall); end
    n_cmp++; if (r_mr !== 3) begin n_bad++; $display("FAIL clean_miss_mread_cycles got=%0d exp=3", r_mr); end
    n_cmp++; if (r_mr_addr !== 28'h4) begin n_bad++; $display("FAIL clean_miss_mem_addr got=%h exp=4", r_mr_addr); end
    n_cmp++; if (r_mw !== 0) begin n_bad++; $display("FAIL clean_miss_mwrite got=%0d exp=0", r_mw); end
    n_cmp++; if (r_rdata !== 32'h11111111) begin n_bad++; $display("FAIL clean_miss_rdata got=%h exp=11111111", r_rdata); end
  endtask

  task automatic test_read_hits;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h22222222; exp_w[1] = 32'h33333333; exp_w[2] = 32'h44444444;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b1, 1'b0, ADDR_W'(32'h11 + i), 32'h0, 128'h0);
      n_cmp++; if (r_stall !== 0 || r_mr !== 0) begin n_bad++; $display("FAIL hit_stall[%0d] got stall=%0d mread=%0d exp=0/0", i, r_stall, r_mr); end
      n_cmp++; if (r_rdata !== exp_w[i]) begin n_bad++; $display("FAIL hit_rdata[%0d] got=%h exp=%h", i, r_rdata, exp_w[i]); end
    end
  endtask

  task automatic test_write_hit;
    run_access(1'b0, 1'b1, 30'h12, 32'hDEADBEEF, 128'h0);
    n_cmp++; if (r_stall !== 0 || r_mr !== 0 || r_mw !== 0) begin n_bad++; $display("FAIL write_hit_traffic got stall=%0d mr=%0d mw=%0d exp=0/0/0", r_stall, r_mr, r_mw); end
    run_access(1'b1, 1'b0, 30'h12, 32'h0, 128'h0);
    n_cmp++; if (r_stall !== 0) begin n_bad++; $display("FAIL write_hit_readback_stall got=%0d exp=0", r_stall); end
    n_cmp++; if (r_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_hit_readback got=%h exp=deadbeef", r_rdata); end
  endtask

  task automatic test_dirty_evict;
    run_access(1'b1, 1'b0, 30'h30, 32'h0, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    n_cmp++; if (r_stall !== 7) begin n_bad++; $display("FAIL evict_stall got=%0d exp=7", r_stall); end
    n_cmp++; if (r_mw !== 3 || r_mr !== 3) begin n_bad++; $display("FAIL evict_cycles got mw=%0d mr=%0d exp=3/3", r_mw, r_mr); end
    n_cmp++; if (r_mw_addr !== 28'h4) begin n_bad++; $display("FAIL evict_wb_addr got=%h exp=4", r_mw_addr); end
    n_cmp++; if (r_mw_data !== 128'h44444444_DEADBEEF_22222222_11111111) begin n_bad++; $display("FAIL evict_wb_data got=%h exp=44444444deadbeef2222222211111111", r_mw_data); end
    n_cmp++; if (r_mr_addr !== 28'hC) begin n_bad++; $display("FAIL evict_fill_addr got=%h exp=c", r_mr_addr); end
    n_cmp++; if (r_rdata !== 32'hA0A0A0A0) begin n_bad++; $display("FAIL evict_rdata got=%h exp=a0a0a0a0", r_rdata); end
    n_cmp++; if (r_both !== 1'b0) begin n_bad++; $display("FAIL evict_rd_wr_overlap got=%b exp=0", r_both); end
    // refilled line is clean: evicting it again needs no write-back
    run_access(1'b1, 1'b0, 30'h13, 32'h0, 128'h44444444_DEADBEEF_22222222_11111111);
    n_cmp++; if (r_stall !== 4 || r_mw !== 0) begin n_bad++; $display("FAIL clean_evict got stall=%0d mw=%0d exp=4/0", r_stall, r_mw); end
    n_cmp++; if (r_rdata !== 32'h44444444) begin n_bad++; $display("FAIL clean_evict_rdata got=%h exp=44444444", r_rdata); end
  endtask

  task automatic test_reset_mid_miss;
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h30;
    @(posedge clk); #1;
    n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL alloc_entered got=%b exp=1", mem_read); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin n_bad++; $display("FAIL async_reset_drop got mread=%b addr=%h exp=0/0", mem_read, mem_addr); end
    proc_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 30'h30, 32'h0, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
    n_cmp++; if (r_stall !== 4 || r_mr !== 3 || r_mw !== 0) begin n_bad++; $display("FAIL post_reset_miss got stall=%0d mr=%0d mw=%0d exp=4/3/0", r_stall, r_mr, r_mw); end
    n_cmp++; if (r_rdata !== 32'hB0B0B0B0) begin n_bad++; $display("FAIL post_reset_rdata got=%h exp=b0b0b0b0", r_rdata); end
  endtask

  task automatic test_read_write_both;
    run_access(1'b1, 1'b1, 30'h31, 32'h12345678, 128'h0);
    n_cmp++; if (r_stall !== 0) begin n_bad++; $display("FAIL both_stall got=%0d exp=0", r_stall); end
    run_access(1'b1, 1'b0, 30'h31, 32'h0, 128'h0);
    n_cmp++; if (r_rdata !== 32'h12345678) begin n_bad++; $display("FAIL both_word got=%h exp=12345678", r_rdata); end
    // conflicting read forces the now-dirty line out
    run_access(1'b1, 1'b0, 30'h10, 32'h0, 128'h44444444_33333333_22222222_11111111);
    n_cmp++; if (r_mw !== 3 || r_mw_addr !== 28'hC) begin n_bad++; $display("FAIL both_dirty got mw=%0d addr=%h exp=3/c", r_mw, r_mw_addr); end
    n_cmp++; if (r_mw_data !== 128'hB3B3B3B3_B2B2B2B2_12345678_B0B0B0B0) begin n_bad++; $display("FAIL both_wb_data got=%h exp=b3b3b3b3b2b2b2b212345678b0b0b0b0", r_mw_data); end
  endtask

  task automatic test_stray_ready;
    mem_ready = 1'b1; mem_rdata = {4{32'hFFFF0000}};
    @(posedge clk); #1;
    mem_ready = 1'b0;
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL stray_ready_memreq got=%b exp=00", {mem_read, mem_write}); end
    run_access(1'b1, 1'b0, 30'h10, 32'h0, 128'h0);
    n_cmp++; if (r_stall !== 0 || r_rdata !== 32'h11111111) begin n_bad++; $display("FAIL stray_ready_line got stall=%0d data=%h exp=0/11111111", r_stall, r_rdata); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_clean_miss();
    test_read_hits();
    test_write_hit();
    test_dirty_evict();
    test_reset_mid_miss();
    test_read_write_both();
    test_stray_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
